// File: rtl/toggle_hs_pkg.sv
// Shared types and default widths for the toggle-handshake responder
// and the matching initiator.
package toggle_hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_VALID   = 2'd2
    } hs_state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sync_chain.sv
// N-stage single-bit synchronizer with asynchronous active-low reset to 0.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_stage;
    logic [STAGES-1:0] w_stage_d;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign w_stage_d[gi] = i_d;
            end else begin : g_rest
                assign w_stage_d[gi] = r_stage[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_stage_d;
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/toggle_hs_receiver.sv
// Responder side of the two-phase toggle handshake: synchronizes req_tgl,
// presents the captured word on valid/ready and toggles ack_tgl on accept.
module toggle_hs_receiver
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              err_overrun,
    input  logic              err_clr
);

    hs_state_t         r_state;
    hs_state_t         w_state_next;
    logic              r_req_seen;
    logic              w_req_seen_next;
    logic              r_ack;
    logic              w_ack_next;
    logic              r_valid;
    logic              w_valid_next;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_err;
    logic              w_err_next;
    logic              w_req_sync;
    logic              w_pend;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (req_tgl),
        .o_q   (w_req_sync)
    );

    assign w_pend = (w_req_sync != r_req_seen);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_req_seen <= w_req_seen_next;
            r_ack      <= w_ack_next;
            r_valid    <= w_valid_next;
            r_data     <= w_data_next;
            r_cnt      <= w_cnt_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_req_seen_next = r_req_seen;
        w_ack_next      = r_ack;
        w_valid_next    = r_valid;
        w_data_next     = r_data;
        w_cnt_next      = r_cnt;
        w_err_next      = r_err;

        case (r_state)
            ST_IDLE: begin
                if (w_pend) begin
                    w_req_seen_next = w_req_sync;
                    w_state_next    = ST_CAPTURE;
                end
            end
            // One cycle after the toggle is seen, so req_data has settled.
            ST_CAPTURE: begin
                w_data_next  = req_data;
                w_valid_next = 1'b1;
                w_state_next = ST_VALID;
            end
            ST_VALID: begin
                if (out_ready) begin
                    w_valid_next = 1'b0;
                    w_ack_next   = ~r_ack;
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // A new toggle while busy stays pending; only the flag records it.
        if (err_clr) begin
            w_err_next = 1'b0;
        end
        if (w_pend && (r_state != ST_IDLE)) begin
            w_err_next = 1'b1;
        end
    end

    assign ack_tgl     = r_ack;
    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign xfer_cnt    = r_cnt;
    assign err_overrun = r_err;

endmodule

// File: tb/tb_toggle_hs_receiver.sv
// Directed bench for toggle_hs_receiver: a default-width instance plus a
// 3-bit-counter instance sharing the same stimulus.
module tb_toggle_hs_receiver;

    logic        clk;
    logic        rst_n;
    logic        req_tgl;
    logic [7:0]  req_data;
    logic        out_ready;
    logic        err_clr;

    logic        ack_tgl;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [15:0] xfer_cnt;
    logic        err_overrun;

    logic        w2_ack_tgl;
    logic        w2_out_valid;
    logic [7:0]  w2_out_data;
    logic [2:0]  w2_xfer_cnt;
    logic        w2_err_overrun;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic exp_ack = 1'b0;

    toggle_hs_receiver #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_tgl(req_tgl), .req_data(req_data),
        .ack_tgl(ack_tgl), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .xfer_cnt(xfer_cnt),
        .err_overrun(err_overrun), .err_clr(err_clr)
    );

    toggle_hs_receiver #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .req_tgl(req_tgl), .req_data(req_data),
        .ack_tgl(w2_ack_tgl), .out_valid(w2_out_valid), .out_data(w2_out_data),
        .out_ready(out_ready), .xfer_cnt(w2_xfer_cnt),
        .err_overrun(w2_err_overrun), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick(1);
            n++;
        end
        chk("valid_wait", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic flip(input logic [7:0] d);
        req_data = d;
        req_tgl  = ~req_tgl;
    endtask

    task automatic accept_check();
        exp_ack = ~exp_ack;
        exp_cnt++;
        chk("ack", {31'd0, ack_tgl}, {31'd0, exp_ack});
        chk("cnt", {16'd0, xfer_cnt}, exp_cnt);
        chk("cnt_w", {29'd0, w2_xfer_cnt}, exp_cnt % 8);
    endtask

    initial begin
        rst_n = 1'b0; req_tgl = 1'b0; req_data = 8'h00; out_ready = 1'b0; err_clr = 1'b0;
        #22;
        chk("rst_ack", {31'd0, ack_tgl}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
        chk("rst_err", {31'd0, err_overrun}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(2);

        // Single transfer: out_valid after edge 4, accept on edge 5
        out_ready = 1'b1;
        flip(8'hA5);
        tick(3);
        chk("single_pre", {31'd0, out_valid}, 32'd0);
        tick(1);
        chk("single_valid", {31'd0, out_valid}, 32'd1);
        chk("single_data", {24'd0, out_data}, 32'hA5);
        chk("single_ack0", {31'd0, ack_tgl}, 32'd0);
        tick(1);
        chk("single_done", {31'd0, out_valid}, 32'd0);
        accept_check();
        chk("single_err", {31'd0, err_overrun}, 32'd0);

        // Downstream stall for 10 cycles
        out_ready = 1'b0;
        flip(8'h3C);
        tick(4);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("stall_hold_v", {31'd0, out_valid}, 32'd1);
            chk("stall_hold_d", {24'd0, out_data}, 32'h3C);
            chk("stall_ack", {31'd0, ack_tgl}, {31'd0, exp_ack});
        end
        out_ready = 1'b1;
        tick(1);
        chk("stall_done", {31'd0, out_valid}, 32'd0);
        chk("stall_keep_d", {24'd0, out_data}, 32'h3C);
        accept_check();

        // Eight-word stream
        for (int i = 1; i <= 8; i++) begin
            flip(i[7:0]);
            wait_valid();
            chk("stream_data", {24'd0, out_data}, i);
            tick(1);
            accept_check();
        end
        chk("stream_ack_end", {31'd0, ack_tgl}, 32'd0);
        chk("stream_err", {31'd0, err_overrun}, 32'd0);

        // Overrun: second toggle 4 cycles after the first, downstream stalled
        out_ready = 1'b0;
        flip(8'h11);
        tick(4);
        chk("ovr_valid", {31'd0, out_valid}, 32'd1);
        flip(8'h22);
        tick(2);
        chk("ovr_not_yet", {31'd0, err_overrun}, 32'd0);
        tick(1);
        chk("ovr_set", {31'd0, err_overrun}, 32'd1);
        chk("ovr_data_held", {24'd0, out_data}, 32'h11);
        out_ready = 1'b1;
        tick(1);
        accept_check();
        wait_valid();
        chk("ovr_data2", {24'd0, out_data}, 32'h22);
        tick(1);
        accept_check();
        chk("ovr_sticky", {31'd0, err_overrun}, 32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("ovr_clear", {31'd0, err_overrun}, 32'd0);

        // Set wins over a simultaneous clear
        out_ready = 1'b0;
        flip(8'h33);
        wait_valid();
        flip(8'h44);
        err_clr = 1'b1;
        tick(2);
        chk("clr_hold", {31'd0, err_overrun}, 32'd0);
        tick(1);
        chk("set_wins", {31'd0, err_overrun}, 32'd1);
        err_clr = 1'b0;
        out_ready = 1'b1;
        tick(1);
        accept_check();
        wait_valid();
        chk("sw_data2", {24'd0, out_data}, 32'h44);
        tick(1);
        accept_check();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("sw_clear", {31'd0, err_overrun}, 32'd0);

        // Reset while in VALID: outputs clear without a clock edge
        out_ready = 1'b0;
        flip(8'h55);
        wait_valid();
        #2 rst_n = 1'b0;
        req_tgl = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_data", {24'd0, out_data}, 32'd0);
        chk("mrst_ack", {31'd0, ack_tgl}, 32'd0);
        chk("mrst_cnt", {16'd0, xfer_cnt}, 32'd0);
        exp_cnt = 0;
        exp_ack = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        tick(8);
        chk("rel0_valid", {31'd0, out_valid}, 32'd0);
        chk("rel0_cnt", {16'd0, xfer_cnt}, 32'd0);
        rst_n = 1'b0;
        req_tgl = 1'b1;
        req_data = 8'h66;
        tick(1);
        rst_n = 1'b1;
        wait_valid();
        chk("rel1_data", {24'd0, out_data}, 32'h66);
        tick(1);
        accept_check();
        tick(6);
        chk("rel1_once", {16'd0, xfer_cnt}, 32'd1);

        // Counter wrap on the 3-bit instance: 1..7, 0, 1
        rst_n = 1'b0;
        req_tgl = 1'b0;
        tick(1);
        rst_n = 1'b1;
        exp_cnt = 0;
        exp_ack = 1'b0;
        chk("wrap_rst", {29'd0, w2_xfer_cnt}, 32'd0);
        for (int i = 0; i < 9; i++) begin
            flip(8'h80 + i[7:0]);
            wait_valid();
            tick(1);
            accept_check();
        end
        chk("wrap_final", {29'd0, w2_xfer_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
